// File: rtl/persistencia_temp.sv
// Sample register, low/high persistence counters and sensor watchdog feeding the temperature-state FSM.
// Optional HISTERESIS_EN: counters are held instead of cleared inside the hysteresis band.
module persistencia_temp #(
   parameter int TEMP_BAJO      = 180,
   parameter int TEMP_ALTO      = 259,
   parameter int N_PERSIST      = 8,
   parameter int TIMEOUT_CICLOS = 1000,
   parameter int TEMP_RESET     = 220,
   parameter int HIST           = 5
) (
   input  logic               clk,
   input  logic               arst_n,
   input  logic signed [10:0] temp_in,
   input  logic               muestra_valida,
   output logic signed [10:0] temp_registrado,
   output logic               muestra_nueva,
   output logic               per_bajo,
   output logic               per_alto,
   output logic               falla_sensor
);

   localparam int CW = $clog2(N_PERSIST + 1);
   localparam int WW = $clog2(TIMEOUT_CICLOS + 1);
   localparam logic [CW-1:0] N_SAT  = CW'(N_PERSIST);
   localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CICLOS);
   // 12-bit signed thresholds so the band edges cannot overflow the 11-bit sample range
   localparam logic signed [11:0] BAJO   = 12'(TEMP_BAJO);
   localparam logic signed [11:0] ALTO   = 12'(TEMP_ALTO);
   localparam logic signed [11:0] BAJO_H = 12'(TEMP_BAJO + HIST);
   localparam logic signed [11:0] ALTO_H = 12'(TEMP_ALTO - HIST);
`ifdef HISTERESIS_EN
   localparam bit HIST_ON = 1'b1;
`else
   localparam bit HIST_ON = 1'b0;
`endif

   typedef enum logic {OK, FALLA} wd_estado_t;

   wd_estado_t         estado_q;
   logic signed [10:0] temp_q;
   logic               nueva_q;
   logic [CW-1:0]      cnt_bajo_q, cnt_bajo_d;
   logic [CW-1:0]      cnt_alto_q, cnt_alto_d;
   logic [WW-1:0]      wd_q, wd_d;
   logic signed [11:0] t_ext;
   logic               es_bajo, es_alto, banda_bajo, banda_alto, expira;

   assign t_ext      = {temp_in[10], temp_in};
   assign es_bajo    = t_ext < BAJO;
   assign es_alto    = t_ext > ALTO;
   assign banda_bajo = HIST_ON && (t_ext >= BAJO) && (t_ext < BAJO_H) && (cnt_bajo_q != '0);
   assign banda_alto = HIST_ON && (t_ext > ALTO_H) && (t_ext <= ALTO) && (cnt_alto_q != '0);

   always_comb begin
      cnt_bajo_d = cnt_bajo_q;
      cnt_alto_d = cnt_alto_q;
      wd_d       = wd_q;
      expira     = 1'b0;
      if (muestra_valida) begin
         wd_d = '0;
         if (es_bajo) begin
            cnt_bajo_d = (cnt_bajo_q == N_SAT) ? N_SAT : cnt_bajo_q + CW'(1);
            cnt_alto_d = '0;
         end else if (es_alto) begin
            cnt_alto_d = (cnt_alto_q == N_SAT) ? N_SAT : cnt_alto_q + CW'(1);
            cnt_bajo_d = '0;
         end else begin
            cnt_bajo_d = banda_bajo ? cnt_bajo_q : '0;
            cnt_alto_d = banda_alto ? cnt_alto_q : '0;
         end
      end else begin
         if (wd_q != WD_MAX) wd_d = wd_q + WW'(1);
         if (wd_d == WD_MAX) begin
            expira     = 1'b1;
            cnt_bajo_d = '0;
            cnt_alto_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         estado_q   <= OK;
         temp_q     <= 11'(TEMP_RESET);
         nueva_q    <= 1'b0;
         cnt_bajo_q <= '0;
         cnt_alto_q <= '0;
         wd_q       <= '0;
      end else begin
         nueva_q    <= muestra_valida;
         cnt_bajo_q <= cnt_bajo_d;
         cnt_alto_q <= cnt_alto_d;
         wd_q       <= wd_d;
         if (muestra_valida) temp_q <= temp_in;
         // a strobe on the expiry edge wins over the timeout
         case (estado_q)
            OK:      if (expira) estado_q <= FALLA;
            FALLA:   if (muestra_valida) estado_q <= OK;
            default: estado_q <= OK;
         endcase
      end
   end

   assign temp_registrado = temp_q;
   assign muestra_nueva   = nueva_q;
   assign per_bajo        = (cnt_bajo_q == N_SAT);
   assign per_alto        = (cnt_alto_q == N_SAT);
   assign falla_sensor    = (estado_q == FALLA);

endmodule

// File: tb/tb_persistencia_temp.sv
// Table-driven bench with an expected-value queue for persistencia_temp.
module tb_persistencia_temp;

   logic               clk = 1'b0;
   logic               arst_n = 1'b0;
   logic signed [10:0] temp_in = '0;
   logic               muestra_valida = 1'b0;
   logic signed [10:0] temp_registrado;
   logic               muestra_nueva, per_bajo, per_alto, falla_sensor;

   persistencia_temp dut (
      .clk             (clk),
      .arst_n          (arst_n),
      .temp_in         (temp_in),
      .muestra_valida  (muestra_valida),
      .temp_registrado (temp_registrado),
      .muestra_nueva   (muestra_nueva),
      .per_bajo        (per_bajo),
      .per_alto        (per_alto),
      .falla_sensor    (falla_sensor)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic signed [10:0] tr;
      logic               nu, b, a, f;
   } exp_t;

   typedef struct {
      logic               v;
      logic signed [10:0] t;
      exp_t               e;
   } vec_t;

`ifdef HISTERESIS_EN
   localparam bit HON = 1'b1;
`else
   localparam bit HON = 1'b0;
`endif

   vec_t               tabla[$];
   exp_t               sb[$];
   int                 n_chk = 0, n_ok = 0;
   logic signed [10:0] ult_t = 11'sd220;

   function automatic exp_t mk(input logic signed [10:0] tr, input logic nu, b, a, f);
      exp_t e;
      e.tr = tr; e.nu = nu; e.b = b; e.a = a; e.f = f;
      return e;
   endfunction

   // temp_registrado/muestra_nueva expectations follow directly from the strobe
   task automatic add(input logic v, input logic signed [10:0] t, input logic b, a);
      vec_t r;
      if (v) ult_t = t;
      r.v = v; r.t = t; r.e = mk(ult_t, v, b, a, 1'b0);
      tabla.push_back(r);
   endtask

   task automatic comparar(input string nombre, input exp_t e);
      exp_t g;
      g = {temp_registrado, muestra_nueva, per_bajo, per_alto, falla_sensor};
      n_chk++;
      if (g === e) n_ok++;
      else $display("FAIL %s: got tr=%0d nu=%b b=%b a=%b f=%b, want tr=%0d nu=%b b=%b a=%b f=%b",
                    nombre, g.tr, g.nu, g.b, g.a, g.f, e.tr, e.nu, e.b, e.a, e.f);
   endtask

   task automatic step(input logic v, input logic signed [10:0] t, input exp_t e, input string nombre);
      muestra_valida = v;
      temp_in        = t;
      sb.push_back(e);
      @(posedge clk);
      #1;
      muestra_valida = 1'b0;
      comparar(nombre, sb.pop_front());
   endtask

   task automatic idle(input int n);
      muestra_valida = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // main sequence: low run with saturation, interrupted high run, polarity swaps, boundaries
      for (int i = 1; i <= 9; i++) add(1'b1, 11'sd150, i >= 8, 1'b0);
      add(1'b0, 11'sd0, 1'b1, 1'b0);
      for (int i = 1; i <= 5; i++) add(1'b1, 11'sd300, 1'b0, 1'b0);
      add(1'b1, 11'sd220, 1'b0, 1'b0);
      for (int i = 1; i <= 8; i++) add(1'b1, 11'sd300, 1'b0, i == 8);
      add(1'b1, 11'sd100, 1'b0, 1'b0);
      for (int i = 1; i <= 7; i++) add(1'b1, 11'sd100, i == 7, 1'b0);
      add(1'b1, 11'sd259, 1'b0, 1'b0);
      for (int i = 1; i <= 8; i++) add(1'b1, 11'sd260, 1'b0, i == 8);
      add(1'b1, 11'sd179, 1'b0, 1'b0);
      add(1'b1, -11'sd1000, 1'b0, 1'b0);

      #12 arst_n = 1'b1;
      idle(10);
      comparar("reset_idle", mk(11'sd220, 1'b0, 1'b0, 1'b0, 1'b0));

      for (int i = 0; i < tabla.size(); i++)
         step(tabla[i].v, tabla[i].t, tabla[i].e, $sformatf("tabla[%0d]", i));

      // asynchronous reset in the middle of a low run (cnt_bajo = 2)
      arst_n = 1'b0;
      #2;
      comparar("reset_async", mk(11'sd220, 1'b0, 1'b0, 1'b0, 1'b0));
      @(posedge clk);
      #1 arst_n = 1'b1;
      for (int i = 1; i <= 8; i++)
         step(1'b1, -11'sd150, mk(-11'sd150, 1'b1, i == 8, 1'b0, 1'b0), $sformatf("post_reset_%0d", i));

      // watchdog expiry drops persistence, next strobe restarts counting from zero
      idle(999);
      comparar("wd_999", mk(-11'sd150, 1'b0, 1'b1, 1'b0, 1'b0));
      step(1'b0, 11'sd0, mk(-11'sd150, 1'b0, 1'b0, 1'b0, 1'b1), "wd_expira");
      step(1'b0, 11'sd0, mk(-11'sd150, 1'b0, 1'b0, 1'b0, 1'b1), "wd_sat");
      step(1'b1, 11'sd150, mk(11'sd150, 1'b1, 1'b0, 1'b0, 1'b0), "wd_recupera");
      for (int i = 2; i <= 8; i++)
         step(1'b1, 11'sd150, mk(11'sd150, 1'b1, i == 8, 1'b0, 1'b0), $sformatf("recount_%0d", i));

      // strobe exactly on the would-be expiry edge
      idle(999);
      step(1'b1, 11'sd150, mk(11'sd150, 1'b1, 1'b1, 1'b0, 1'b0), "wd_strobe_1000");

      // hysteresis band edges
      step(1'b1, 11'sd182, mk(11'sd182, 1'b1, HON, 1'b0, 1'b0), "hist_bajo_182");
      step(1'b1, 11'sd185, mk(11'sd185, 1'b1, 1'b0, 1'b0, 1'b0), "hist_bajo_185");
      for (int i = 1; i <= 8; i++)
         step(1'b1, 11'sd300, mk(11'sd300, 1'b1, 1'b0, i == 8, 1'b0), $sformatf("alto_run_%0d", i));
      step(1'b1, 11'sd256, mk(11'sd256, 1'b1, 1'b0, HON, 1'b0), "hist_alto_256");
      step(1'b1, 11'sd254, mk(11'sd254, 1'b1, 1'b0, 1'b0, 1'b0), "hist_alto_254");

      $display("%0d/%0d checks passed", n_ok, n_chk);
      $finish;
   end

endmodule
